btn_conditioner: RTL and testbench

//  Conditions the raw board push-buttons before they drive the btn[3:0] input of the LED logic stage.
//  Per channel: N-stage synchronizer, consecutive-sample debounce counter, one-cycle rise/fall pulses, long-press flag.
//  btn_db connects directly to LED.btn; the pulse and hold outputs serve later control logic.

---
 rtl/btn_pkg.sv | 23 ++
 rtl/btn_debounce_ch.sv | 96 +++++++++
 rtl/btn_conditioner.sv | 42 ++++
 tb/tb_btn_conditioner.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | btn_pkg : shared types, default timing constants and a width helper  |
// |           for the push-button conditioning slice.                    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package btn_pkg;

   typedef enum logic [0:0] {
      ST_STABLE  = 1'b0,
      ST_PENDING = 1'b1
   } db_state_t;

   localparam int c_db_cycles_default   = 1_000_000;
   localparam int c_hold_cycles_default = 50_000_000;

   // Bits needed to hold values 0..max_val inclusive.
   function automatic int cnt_w(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce_ch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | btn_debounce_ch : one button channel - synchronizer, debounce FSM,   |
// |                   rise/fall pulse registers and long-press counter.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module btn_debounce_ch
   import btn_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int DB_CYCLES   = c_db_cycles_default,
   parameter int HOLD_CYCLES = c_hold_cycles_default
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic db,
   output logic rise,
   output logic fall,
   output logic hold
);

   localparam int c_cnt_w  = cnt_w(DB_CYCLES);
   localparam int c_hcnt_w = cnt_w(HOLD_CYCLES);
   localparam logic [c_cnt_w-1:0]  c_db_last  = c_cnt_w'(DB_CYCLES - 1);
   localparam logic [c_hcnt_w-1:0] c_hold_max = c_hcnt_w'(HOLD_CYCLES);

   logic [SYNC_STAGES-1:0] r_sync;
   db_state_t              r_state;
   db_state_t              w_state_nxt;
   logic [c_cnt_w-1:0]     r_cnt;
   logic [c_hcnt_w-1:0]    r_hcnt;
   logic                   r_db;
   logic                   r_rise;
   logic                   r_fall;
   logic                   w_s;
   logic                   w_diff;
   logic                   w_accept;

   assign w_s    = r_sync[SYNC_STAGES-1];
   assign w_diff = w_s ^ r_db;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync  <= '0;
         r_state <= ST_STABLE;
         r_cnt   <= '0;
         r_hcnt  <= '0;
         r_db    <= 1'b0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
      end else begin
         r_sync  <= {r_sync[SYNC_STAGES-2:0], raw};
         r_state <= w_state_nxt;
         // Any agreeing sample restarts the consecutive-sample count.
         if (w_accept || !w_diff)
            r_cnt <= '0;
         else
            r_cnt <= r_cnt + c_cnt_w'(1);
         if (w_accept)
            r_db <= w_s;
         r_rise <= w_accept & w_s;
         r_fall <= w_accept & ~w_s;
         // Clearing on the falling accept drops hold together with db.
         if (!r_db || w_accept)
            r_hcnt <= '0;
         else if (r_hcnt != c_hold_max)
            r_hcnt <= r_hcnt + c_hcnt_w'(1);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_STABLE:  if (w_diff && !w_accept) w_state_nxt = ST_PENDING;
         ST_PENDING: if (!w_diff || w_accept) w_state_nxt = ST_STABLE;
         default:    w_state_nxt = ST_STABLE;
      endcase
   end

   always_comb begin
      w_accept = 1'b0;
      case (r_state)
         ST_STABLE:  w_accept = w_diff && (DB_CYCLES == 1);
         ST_PENDING: w_accept = w_diff && (r_cnt == c_db_last);
         default:    w_accept = 1'b0;
      endcase
   end

   assign db   = r_db;
   assign rise = r_rise;
   assign fall = r_fall;
   assign hold = (r_hcnt == c_hold_max);

endmodule
`default_nettype wire

// File: rtl/btn_conditioner.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | btn_conditioner : N_BTN independent push-button conditioning chans.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module btn_conditioner
   import btn_pkg::*;
#(
   parameter int N_BTN       = 4,
   parameter int SYNC_STAGES = 2,
   parameter int DB_CYCLES   = c_db_cycles_default,
   parameter int HOLD_CYCLES = c_hold_cycles_default
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] btn_db,
   output logic [N_BTN-1:0] btn_rise,
   output logic [N_BTN-1:0] btn_fall,
   output logic [N_BTN-1:0] btn_hold
);

   generate
      for (genvar i = 0; i < N_BTN; i++) begin : g_ch
         btn_debounce_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_CYCLES   (DB_CYCLES),
            .HOLD_CYCLES (HOLD_CYCLES)
         ) u_ch (
            .clk  (clk),
            .rst  (rst),
            .raw  (btn_raw[i]),
            .db   (btn_db[i]),
            .rise (btn_rise[i]),
            .fall (btn_fall[i]),
            .hold (btn_hold[i])
         );
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_btn_conditioner.sv
`default_nettype none
// Bench for btn_conditioner: directed scenarios plus random bouncing inputs,
// compared every cycle against a cycle-level behavioural model.
module tb_btn_conditioner;

   localparam int NB   = 4;
   localparam int SYNC = 2;
   localparam int DB   = 4;
   localparam int HOLD = 10;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NB-1:0] btn_raw = '0;
   logic [NB-1:0] btn_db, btn_rise, btn_fall, btn_hold;

   int n_cmp = 0;
   int n_err = 0;

   // Model state: raw samples in flight through the synchronizer, the
   // accepted level, run length of disagreeing samples, cycles spent high.
   logic [NB-1:0] m_hist [SYNC];
   logic [NB-1:0] m_db = '0, m_rise = '0, m_fall = '0, m_hold = '0;
   int            m_run  [NB];
   int            m_high [NB];

   always #5 clk = ~clk;

   btn_conditioner #(
      .N_BTN       (NB),
      .SYNC_STAGES (SYNC),
      .DB_CYCLES   (DB),
      .HOLD_CYCLES (HOLD)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .btn_raw  (btn_raw),
      .btn_db   (btn_db),
      .btn_rise (btn_rise),
      .btn_fall (btn_fall),
      .btn_hold (btn_hold)
   );

   function automatic void model_step();
      logic [NB-1:0] s;
      if (rst) begin
         for (int k = 0; k < SYNC; k++) m_hist[k] = '0;
         for (int c = 0; c < NB; c++) begin
            m_run[c]  = 0;
            m_high[c] = 0;
         end
         m_db = '0; m_rise = '0; m_fall = '0; m_hold = '0;
      end else begin
         s = m_hist[SYNC-1];
         for (int k = SYNC-1; k > 0; k--) m_hist[k] = m_hist[k-1];
         m_hist[0] = btn_raw;
         m_rise = '0;
         m_fall = '0;
         for (int c = 0; c < NB; c++) begin
            logic was_high;
            was_high = m_db[c];
            if (s[c] != m_db[c]) begin
               m_run[c]++;
               if (m_run[c] >= DB) begin
                  m_db[c]  = s[c];
                  m_run[c] = 0;
                  if (s[c]) m_rise[c] = 1'b1;
                  else      m_fall[c] = 1'b1;
               end
            end else begin
               m_run[c] = 0;
            end
            if (!m_db[c])      m_high[c] = 0;
            else if (was_high) m_high[c]++;
            m_hold[c] = m_db[c] && (m_high[c] >= HOLD);
         end
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic settle(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      btn_raw = 4'hF;
      for (int k = 0; k < 3; k++) begin
         tick();
         n_cmp++;
         if ({btn_db, btn_rise, btn_fall, btn_hold} !== 16'h0) begin
            n_err++;
            $display("FAIL reset_outputs cyc%0d: got %h required 0", k,
                     {btn_db, btn_rise, btn_fall, btn_hold});
         end
      end
      rst = 1'b0;
      btn_raw = '0;
      tick();
      n_cmp++;
      if ({btn_db, btn_rise, btn_fall, btn_hold} !== 16'h0) begin
         n_err++;
         $display("FAIL reset_after: got %h required 0", {btn_db, btn_rise, btn_fall, btn_hold});
      end
   endtask

   task automatic test_clean_press();
      btn_raw[0] = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         n_cmp++;
         if ({btn_db[0], btn_rise[0]} !== {1'(k >= 6), 1'(k == 6)}) begin
            n_err++;
            $display("FAIL clean_press edge%0d: db/rise got %b%b required %b%b", k,
                     btn_db[0], btn_rise[0], k >= 6, k == 6);
         end
      end
      btn_raw[0] = 1'b0;
      settle(8);
   endtask

   task automatic test_bounce();
      int rises = 0;
      for (int k = 1; k <= 20; k++) begin
         btn_raw[1] = (k > 10) ? 1'b1 : ~((k - 1) / 2 % 2 == 1);
         tick();
         if (btn_rise[1]) rises++;
         n_cmp++;
         if ({btn_db[1], btn_rise[1]} !== {1'(k >= 14), 1'(k == 14)}) begin
            n_err++;
            $display("FAIL bounce edge%0d: db/rise got %b%b required %b%b", k,
                     btn_db[1], btn_rise[1], k >= 14, k == 14);
         end
         n_cmp++;
         if ({btn_db, btn_rise, btn_fall, btn_hold} !== {m_db, m_rise, m_fall, m_hold}) begin
            n_err++;
            $display("FAIL bounce_model edge%0d: got %h required %h", k,
                     {btn_db, btn_rise, btn_fall, btn_hold}, {m_db, m_rise, m_fall, m_hold});
         end
      end
      n_cmp++;
      if (rises !== 1) begin
         n_err++;
         $display("FAIL bounce_rise_count: got %0d required 1", rises);
      end
      btn_raw[1] = 1'b0;
      settle(8);
   endtask

   task automatic test_hold();
      btn_raw[2] = 1'b1;
      for (int k = 1; k <= 18; k++) begin
         tick();
         n_cmp++;
         if ({btn_db[2], btn_hold[2]} !== {1'(k >= 6), 1'(k >= 16)}) begin
            n_err++;
            $display("FAIL hold_press edge%0d: db/hold got %b%b required %b%b", k,
                     btn_db[2], btn_hold[2], k >= 6, k >= 16);
         end
      end
      btn_raw[2] = 1'b0;
      for (int j = 1; j <= 7; j++) begin
         tick();
         n_cmp++;
         if ({btn_db[2], btn_fall[2], btn_hold[2]} !== {1'(j < 6), 1'(j == 6), 1'(j < 6)}) begin
            n_err++;
            $display("FAIL hold_release edge%0d: db/fall/hold got %b%b%b required %b%b%b", j,
                     btn_db[2], btn_fall[2], btn_hold[2], j < 6, j == 6, j < 6);
         end
      end
      settle(4);
   endtask

   task automatic test_simultaneous();
      btn_raw = 4'hF;
      for (int k = 1; k <= 8; k++) begin
         tick();
         n_cmp++;
         if ({btn_db, btn_rise} !== {((k >= 6) ? 4'hF : 4'h0), ((k == 6) ? 4'hF : 4'h0)}) begin
            n_err++;
            $display("FAIL simultaneous edge%0d: db/rise got %h/%h", k, btn_db, btn_rise);
         end
      end
      btn_raw = 4'h0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         n_cmp++;
         if ({btn_db, btn_fall} !== {((k < 6) ? 4'hF : 4'h0), ((k == 6) ? 4'hF : 4'h0)}) begin
            n_err++;
            $display("FAIL simultaneous_fall edge%0d: db/fall got %h/%h", k, btn_db, btn_fall);
         end
      end
   endtask

   task automatic test_reset_mid();
      btn_raw[3] = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         tick();
         n_cmp++;
         if ({btn_db[3], btn_rise[3]} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_mid_pre edge%0d: db/rise got %b%b required 00", k, btn_db[3], btn_rise[3]);
         end
      end
      rst = 1'b1;
      tick();
      n_cmp++;
      if ({btn_db, btn_rise, btn_fall, btn_hold} !== 16'h0) begin
         n_err++;
         $display("FAIL reset_mid_rst: got %h required 0", {btn_db, btn_rise, btn_fall, btn_hold});
      end
      rst = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         n_cmp++;
         if ({btn_db[3], btn_rise[3]} !== {1'(k >= 6), 1'(k == 6)}) begin
            n_err++;
            $display("FAIL reset_mid_requal edge%0d: db/rise got %b%b required %b%b", k,
                     btn_db[3], btn_rise[3], k >= 6, k == 6);
         end
      end
      btn_raw[3] = 1'b0;
      settle(8);
   endtask

   task automatic test_random();
      for (int k = 0; k < 600; k++) begin
         int odds;
         odds = (k < 300) ? 6 : 30;
         for (int c = 0; c < NB; c++)
            if ($urandom_range(odds - 1, 0) == 0) btn_raw[c] = ~btn_raw[c];
         rst = ($urandom_range(149, 0) == 0);
         tick();
         n_cmp++;
         if ({btn_db, btn_rise, btn_fall, btn_hold} !== {m_db, m_rise, m_fall, m_hold}) begin
            n_err++;
            $display("FAIL random_model cyc%0d: got %h required %h", k,
                     {btn_db, btn_rise, btn_fall, btn_hold}, {m_db, m_rise, m_fall, m_hold});
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_hold();
      test_simultaneous();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
